// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and widths for the Avalon-style bus arbiter.
package mips_bus_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

  localparam int ARB_MAX_M = 4;
  localparam int BE_W      = 4;
  localparam int DW        = 32;

endpackage

// File: rtl/mips_bus_arbiter_rr_pick.sv
// rtl/mips_bus_arbiter_rr_pick.sv - combinational one-hot winner select (rr_pick).
// MIPS_BUS_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores last.
import mips_bus_pkg::*;

module rr_pick #(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [NUM_M-1:0] last,
  output logic [NUM_M-1:0] win
);

`ifdef MIPS_BUS_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    win = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`else
  // Search starts one past the last-granted master; an empty last means master 0 first.
  always_comb begin
    int start;
    int idx;
    logic found;
    win   = '0;
    start = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (last[i]) start = (i + 1) % NUM_M;
    end
    for (int k = 0; k < NUM_M; k++) begin
      idx = (start + k) % NUM_M;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - shares one Avalon-style bus between NUM_M masters.
// Round-robin by default; MIPS_BUS_ARB_FIXED_PRIO_EN selects fixed priority.
import mips_bus_pkg::*;

module mips_bus_arbiter #(
  parameter int NUM_M = 2,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_M-1:0]      m_read,
  input  logic [NUM_M-1:0]      m_write,
  input  logic [NUM_M*AW-1:0]   m_address,
  input  logic [NUM_M*DW-1:0]   m_writedata,
  input  logic [NUM_M*BE_W-1:0] m_byteenable,
  output logic [DW-1:0]         m_readdata,
  output logic [NUM_M-1:0]      m_waitrequest,
  output logic [AW-1:0]         s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DW-1:0]         s_writedata,
  output logic [BE_W-1:0]       s_byteenable,
  input  logic [DW-1:0]         s_readdata,
  input  logic                  s_waitrequest,
  output logic [NUM_M-1:0]      grant,
  output logic                  busy
);

  arb_state_t       state_q;
  logic [NUM_M-1:0] grant_q;
  logic             busy_q;
  logic [NUM_M-1:0] last_q;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] grant_d;
  logic             xfer;
  logic             xfer_end;
  logic             g_read;
  logic             g_write;
  logic [AW-1:0]    g_addr;
  logic [DW-1:0]    g_wdata;
  logic [BE_W-1:0]  g_be;

  assign req  = m_read | m_write;
  assign xfer = (state_q == ARB_XFER);

  always_comb begin
    g_read  = 1'b0;
    g_write = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        g_read  = m_read[i];
        g_write = m_write[i];
        g_addr  = m_address[i*AW +: AW];
        g_wdata = m_writedata[i*DW +: DW];
        g_be    = m_byteenable[i*BE_W +: BE_W];
      end
    end
  end

  // Read+write together is treated as a write.
  assign s_write      = xfer & g_write;
  assign s_read       = xfer & g_read & ~g_write;
  assign s_address    = xfer ? g_addr  : '0;
  assign s_writedata  = xfer ? g_wdata : '0;
  assign s_byteenable = xfer ? g_be    : '0;
  assign m_readdata   = s_readdata;

  // Outside XFER every master is stalled, matching the reset value.
  always_comb begin
    m_waitrequest = '1;
    if (xfer) begin
      for (int i = 0; i < NUM_M; i++) begin
        m_waitrequest[i] = grant_q[i] ? s_waitrequest : req[i];
      end
    end
  end

  // Ends on a completed strobe or when the granted master withdrew its request.
  assign xfer_end = ~((s_read | s_write) & s_waitrequest);

`ifdef MIPS_BUS_ARB_FIXED_PRIO_EN
  assign last_q = '0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (xfer && xfer_end) begin
      last_q <= grant_q;
    end
  end
`endif

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req  (req),
    .last (last_q),
    .win  (grant_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            state_q <= ARB_XFER;
            grant_q <= grant_d;
            busy_q  <= 1'b1;
          end
        end
        ARB_XFER: begin
          if (xfer_end) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
